// File: rtl/uart_tx_framed.sv
`timescale 1ns/1ps
// uart_tx_framed
// FIFO-fed UART transmitter. It pops one word at a time from an external FIFO,
// then serialises it as: start bit, p_bit_cnt data bits (LSB first), an optional
// parity bit, and one or two stop bits.
// The divisor, stop-bit count and parity mode are latched once per frame.
// Changing those inputs mid-frame therefore only affects the next frame.
//
// Optional feature: define UART_TX_FRAMED_PARITY_EN to compile in the PARITY
// state and decoding of i_parity. Without it, i_parity is ignored and frames are
// start + data + stop only.
//
// Parameters
//   p_bit_cnt       data bits per frame (5..9)
//   p_div_w         width of the runtime baud divisor
// Ports
//   i_clk           clock, rising edge
//   i_rst           synchronous active-high reset
//   i_div           clock cycles per UART bit (values below 2 act as 2)
//   i_stop2         1 = two stop bits, 0 = one
//   i_parity        00/11 none, 01 even, 10 odd (parity build only)
//   i_fifo_rd_data  FIFO word, valid the cycle after o_fifo_rd_en
//   i_fifo_empty    FIFO empty flag
//   o_fifo_rd_en    one-cycle FIFO pop strobe (high exactly while in REQ)
//   o_sig           serial line, idle high
//   o_busy          high from REQ through the last stop bit
//   o_done          one-cycle pulse after the last stop-bit period
module uart_tx_framed #(
  parameter int p_bit_cnt = 8,
  parameter int p_div_w   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [p_div_w-1:0]   i_div,
  input  logic                 i_stop2,
  input  logic [1:0]           i_parity,
  input  logic [p_bit_cnt-1:0] i_fifo_rd_data,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_rd_en,
  output logic                 o_sig,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int                  lp_idx_w    = $clog2(p_bit_cnt);
  localparam logic [lp_idx_w-1:0] lp_last_idx = lp_idx_w'(p_bit_cnt - 1);
  localparam logic [lp_idx_w-1:0] lp_idx_one  = lp_idx_w'(1);
  localparam logic [p_div_w-1:0]  lp_one      = p_div_w'(1);
  localparam logic [p_div_w-1:0]  lp_two      = p_div_w'(2);

`ifdef UART_TX_FRAMED_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_REQ, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_REQ, S_LOAD, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t               r_state;
  logic [p_div_w-1:0]   r_div;
  logic [p_div_w-1:0]   r_cnt;
  logic [p_bit_cnt-1:0] r_shift;
  logic [lp_idx_w-1:0]  r_bit_idx;
  logic                 r_stop2;
  logic                 r_stop_idx;
  // The line is stored inverted so that an all-zero power-up register image
  // matches the reset state (IDLE, line high, no strobes).
  logic                 r_sig_n;
  logic                 r_rd_en;
  logic                 r_busy;
  logic                 r_done;

`ifdef UART_TX_FRAMED_PARITY_EN
  logic                 r_par_en;
  logic                 r_par_bit;
`else
  logic                 w_unused_parity;
  assign w_unused_parity = ^i_parity;
`endif

  logic                 w_bit_end;
  logic [p_div_w-1:0]   w_div_eff;

  // A one-cycle bit would leave no room for the counter to run, so the
  // divisor is clamped to 2.
  assign w_div_eff = (i_div < lp_two) ? lp_two : i_div;
  assign w_bit_end = (r_cnt == (r_div - lp_one));

  assign o_sig        = ~r_sig_n;
  assign o_fifo_rd_en = r_rd_en;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_sig_n    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!i_fifo_empty) begin
            r_state <= S_REQ;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_REQ: begin
          r_state <= S_LOAD;
        end
        // The popped word arrives this cycle; the frame configuration is
        // frozen here as well.
        S_LOAD: begin
          r_shift <= i_fifo_rd_data;
          r_div   <= w_div_eff;
          r_stop2 <= i_stop2;
`ifdef UART_TX_FRAMED_PARITY_EN
          r_par_en  <= (i_parity == 2'b01) || (i_parity == 2'b10);
          r_par_bit <= (^i_fifo_rd_data) ^ (i_parity == 2'b10);
`endif
          r_cnt   <= '0;
          r_sig_n <= 1'b1;
          r_state <= S_START;
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_sig_n   <= ~r_shift[0];
            r_shift   <= r_shift >> 1;
            r_state   <= S_DATA;
          end else begin
            r_cnt <= r_cnt + lp_one;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == lp_last_idx) begin
`ifdef UART_TX_FRAMED_PARITY_EN
              if (r_par_en) begin
                r_sig_n <= ~r_par_bit;
                r_state <= S_PARITY;
              end else begin
                r_sig_n    <= 1'b0;
                r_stop_idx <= 1'b0;
                r_state    <= S_STOP;
              end
`else
              r_sig_n    <= 1'b0;
              r_stop_idx <= 1'b0;
              r_state    <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + lp_idx_one;
              r_sig_n   <= ~r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end else begin
            r_cnt <= r_cnt + lp_one;
          end
        end
`ifdef UART_TX_FRAMED_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt      <= '0;
            r_sig_n    <= 1'b0;
            r_stop_idx <= 1'b0;
            r_state    <= S_STOP;
          end else begin
            r_cnt <= r_cnt + lp_one;
          end
        end
`endif
        // At the end of the final stop period the FIFO is checked again so
        // queued words follow with only the REQ and LOAD cycles in between.
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_stop2 && !r_stop_idx) begin
              r_stop_idx <= 1'b1;
            end else begin
              r_done <= 1'b1;
              if (!i_fifo_empty) begin
                r_state <= S_REQ;
                r_rd_en <= 1'b1;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end else begin
            r_cnt <= r_cnt + lp_one;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
`timescale 1ns/1ps
// tb_uart_tx_framed
// Directed bench for uart_tx_framed (default parameters). A small FIFO model
// feeds the DUT. Every output is sampled on the falling edge into trace arrays,
// and each scenario compares the traces against hand-derived frame timelines.
module tb_uart_tx_framed;

  logic        clk;
  logic        rst;
  logic [15:0] div;
  logic        stop2;
  logic [1:0]  parity;
  logic [7:0]  fifoRdData;
  logic        fifoEmpty;
  logic        rdEn;
  logic        sig;
  logic        busy;
  logic        done;

  int testsRun;
  int testsFailed;

`ifdef UART_TX_FRAMED_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  // Tiny FIFO model: the stimulus writes entries, the DUT pops them, and
  // popped data appears one cycle after the strobe.
  logic [7:0] fifoMem [0:15];
  logic [3:0] wrPtr;
  logic [3:0] rdPtr;
  logic       fifoInit;

  assign fifoEmpty = (wrPtr == rdPtr);

  always @(posedge clk) begin
    if (fifoInit) begin
      rdPtr <= 4'd0;
    end else if (rdEn) begin
      fifoRdData <= fifoMem[rdPtr];
      rdPtr      <= rdPtr + 4'd1;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  uart_tx_framed dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_div          (div),
    .i_stop2        (stop2),
    .i_parity       (parity),
    .i_fifo_rd_data (fifoRdData),
    .i_fifo_empty   (fifoEmpty),
    .o_fifo_rd_en   (rdEn),
    .o_sig          (sig),
    .o_busy         (busy),
    .o_done         (done)
  );

  logic sigTr  [0:1023];
  logic busyTr [0:1023];
  logic rdTr   [0:1023];
  logic doneTr [0:1023];
  logic expSig [0:1023];
  int   trIdx;
  int   badIdx;

  task automatic pushByte(input logic [7:0] b);
    fifoMem[wrPtr] = b;
    wrPtr = wrPtr + 4'd1;
  endtask

  task automatic startTrace();
    trIdx = 0;
    for (int i = 0; i < 1024; i++) expSig[i] = 1'b1;
  endtask

  task automatic captureTrace(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sigTr[trIdx]  = sig;
      busyTr[trIdx] = busy;
      rdTr[trIdx]   = rdEn;
      doneTr[trIdx] = done;
      trIdx++;
    end
  endtask

  // Writes the expected line levels of one frame starting at sample s and
  // returns the index of the first sample after the final stop period.
  task automatic buildFrame(input int s, input logic [7:0] data, input int dv,
                            input bit twoStop, input logic [1:0] par, output int e);
    int p;
    int d;
    logic pb;
    d = (dv < 2) ? 2 : dv;
    p = s;
    for (int c = 0; c < d; c++) begin expSig[p] = 1'b0; p++; end
    for (int b = 0; b < 8; b++)
      for (int c = 0; c < d; c++) begin expSig[p] = data[b]; p++; end
    if (PAR_BUILT && (par == 2'b01 || par == 2'b10)) begin
      pb = (^data) ^ (par == 2'b10);
      for (int c = 0; c < d; c++) begin expSig[p] = pb; p++; end
    end
    for (int c = 0; c < d * (twoStop ? 2 : 1); c++) begin expSig[p] = 1'b1; p++; end
    e = p;
  endtask

  function automatic int sigDiffs(input int n);
    int cnt;
    cnt = 0;
    badIdx = 0;
    for (int i = 0; i < n; i++)
      if (sigTr[i] !== expSig[i]) begin
        if (cnt == 0) badIdx = i;
        cnt++;
      end
    return cnt;
  endfunction

  function automatic int countRd(input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) if (rdTr[i] === 1'b1) cnt++;
    return cnt;
  endfunction

  function automatic int countDone(input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) if (doneTr[i] === 1'b1) cnt++;
    return cnt;
  endfunction

  function automatic int countBusy(input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) if (busyTr[i] === 1'b1) cnt++;
    return cnt;
  endfunction

  // Reset values, then confirm the block stays idle with an empty FIFO.
  task automatic test_reset();
    rst = 1'b1;
    fifoInit = 1'b1;
    wrPtr = 4'd0;
    div = 16'd4;
    stop2 = 1'b0;
    parity = 2'b00;
    @(negedge clk);
    @(negedge clk);
    testsRun++;
    if (sig !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_sig: got %b expected 1", sig); end
    testsRun++;
    if (rdEn !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_rd_en: got %b expected 0", rdEn); end
    testsRun++;
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    testsRun++;
    if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    fifoInit = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    testsRun++;
    if ({sig, busy, rdEn} !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL idle_after_reset: sig/busy/rd got %b expected 100", {sig, busy, rdEn});
    end
  endtask

  // 0x55, divisor 4, one stop bit.
  task automatic test_basic();
    int e;
    int n;
    @(negedge clk);
    div = 16'd4;
    startTrace();
    pushByte(8'h55);
    captureTrace(48);
    buildFrame(2, 8'h55, 4, 1'b0, 2'b00, e);
    n = sigDiffs(48);
    testsRun++;
    if (n != 0) begin testsFailed++; $display("[TB] FAIL basic_sig: %0d samples differ, first at %0d got %b expected %b", n, badIdx, sigTr[badIdx], expSig[badIdx]); end
    testsRun++;
    if (countRd(48) != 1 || rdTr[0] !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_rd_en: count %0d first %b expected 1 pulse at sample 0", countRd(48), rdTr[0]); end
    testsRun++;
    if (countDone(48) != 1 || doneTr[e] !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_done: count %0d at %0d = %b expected single pulse", countDone(48), e, doneTr[e]); end
    testsRun++;
    if (countBusy(48) != e) begin testsFailed++; $display("[TB] FAIL basic_busy: %0d busy cycles expected %0d", countBusy(48), e); end
  endtask

  // 0x07 at divisor 3 with even then odd parity requested.
  task automatic test_parity();
    int e;
    int n;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      div = 16'd3;
      parity = (k == 0) ? 2'b01 : 2'b10;
      startTrace();
      pushByte(8'h07);
      captureTrace(40);
      buildFrame(2, 8'h07, 3, 1'b0, parity, e);
      n = sigDiffs(40);
      testsRun++;
      if (n != 0) begin testsFailed++; $display("[TB] FAIL parity_sig mode %0d: %0d samples differ, first at %0d got %b expected %b", parity, n, badIdx, sigTr[badIdx], expSig[badIdx]); end
      testsRun++;
      if (doneTr[e] !== 1'b1) begin testsFailed++; $display("[TB] FAIL parity_done_pos mode %0d: done at %0d = %b expected 1", parity, e, doneTr[e]); end
      testsRun++;
      if (countDone(40) != 1) begin testsFailed++; $display("[TB] FAIL parity_done_cnt mode %0d: got %0d expected 1", parity, countDone(40)); end
    end
    parity = 2'b00;
  endtask

  // Two stop bits, divisor 5, two words queued at once.
  task automatic test_back_to_back();
    int e1;
    int e2;
    int n;
    @(negedge clk);
    div = 16'd5;
    stop2 = 1'b1;
    startTrace();
    pushByte(8'hA3);
    pushByte(8'h3C);
    captureTrace(120);
    buildFrame(2, 8'hA3, 5, 1'b1, 2'b00, e1);
    buildFrame(e1 + 2, 8'h3C, 5, 1'b1, 2'b00, e2);
    n = sigDiffs(120);
    testsRun++;
    if (n != 0) begin testsFailed++; $display("[TB] FAIL b2b_sig: %0d samples differ, first at %0d got %b expected %b", n, badIdx, sigTr[badIdx], expSig[badIdx]); end
    testsRun++;
    if (countRd(120) != 2 || rdTr[e1] !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_rd_en: count %0d, at %0d = %b expected 2 pulses", countRd(120), e1, rdTr[e1]); end
    testsRun++;
    if (countDone(120) != 2 || doneTr[e1] !== 1'b1 || doneTr[e2] !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_done: count %0d, %b %b expected pulses at %0d and %0d", countDone(120), doneTr[e1], doneTr[e2], e1, e2); end
    testsRun++;
    if (countBusy(120) != e2) begin testsFailed++; $display("[TB] FAIL b2b_busy: %0d busy cycles expected %0d", countBusy(120), e2); end
    stop2 = 1'b0;
  endtask

  // Divisors 0 and 1 both give 2-cycle bits.
  task automatic test_small_div();
    int e;
    int n;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      div = 16'(k);
      startTrace();
      pushByte((k == 0) ? 8'h0F : 8'hF0);
      captureTrace(26);
      buildFrame(2, (k == 0) ? 8'h0F : 8'hF0, 2, 1'b0, 2'b00, e);
      n = sigDiffs(26);
      testsRun++;
      if (n != 0) begin testsFailed++; $display("[TB] FAIL small_div_sig div %0d: %0d samples differ, first at %0d got %b expected %b", k, n, badIdx, sigTr[badIdx], expSig[badIdx]); end
      testsRun++;
      if (doneTr[e] !== 1'b1) begin testsFailed++; $display("[TB] FAIL small_div_done div %0d: at %0d got %b expected 1", k, e, doneTr[e]); end
    end
  endtask

  // Reset during data bit 3 of an all-zero word, then a fresh frame.
  task automatic test_reset_mid_frame();
    int e1;
    int e2;
    int n;
    @(negedge clk);
    div = 16'd4;
    startTrace();
    pushByte(8'h00);
    captureTrace(20);
    rst = 1'b1;
    captureTrace(1);
    testsRun++;
    if (sigTr[20] !== 1'b1 || busyTr[20] !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_abort: sig %b busy %b expected 1 0", sigTr[20], busyTr[20]); end
    pushByte(8'hC3);
    captureTrace(1);
    rst = 1'b0;
    captureTrace(48);
    buildFrame(2, 8'h00, 4, 1'b0, 2'b00, e1);
    for (int i = 20; i < 24; i++) expSig[i] = 1'b1;
    buildFrame(24, 8'hC3, 4, 1'b0, 2'b00, e2);
    n = sigDiffs(70);
    testsRun++;
    if (n != 0) begin testsFailed++; $display("[TB] FAIL midrst_sig: %0d samples differ, first at %0d got %b expected %b", n, badIdx, sigTr[badIdx], expSig[badIdx]); end
    testsRun++;
    if (countDone(70) != 1 || doneTr[e2] !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_done: count %0d, at %0d = %b expected only the second frame", countDone(70), e2, doneTr[e2]); end
    testsRun++;
    if (countRd(70) != 2 || rdTr[22] !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_rd_en: count %0d, at 22 = %b expected 2 pulses", countRd(70), rdTr[22]); end
  endtask

  // Divisor changes from 4 to 8 while the first of two queued words is on the line.
  task automatic test_div_change();
    int e1;
    int e2;
    int n;
    @(negedge clk);
    div = 16'd4;
    startTrace();
    pushByte(8'h96);
    pushByte(8'h5A);
    captureTrace(10);
    div = 16'd8;
    captureTrace(120);
    buildFrame(2, 8'h96, 4, 1'b0, 2'b00, e1);
    buildFrame(e1 + 2, 8'h5A, 8, 1'b0, 2'b00, e2);
    n = sigDiffs(130);
    testsRun++;
    if (n != 0) begin testsFailed++; $display("[TB] FAIL divchg_sig: %0d samples differ, first at %0d got %b expected %b", n, badIdx, sigTr[badIdx], expSig[badIdx]); end
    testsRun++;
    if (doneTr[e1] !== 1'b1 || doneTr[e2] !== 1'b1) begin testsFailed++; $display("[TB] FAIL divchg_done: %b %b expected 1 1 at %0d %0d", doneTr[e1], doneTr[e2], e1, e2); end
    testsRun++;
    if (countBusy(130) != e2) begin testsFailed++; $display("[TB] FAIL divchg_busy: %0d busy cycles expected %0d", countBusy(130), e2); end
    div = 16'd4;
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_small_div();
    test_reset_mid_frame();
    test_div_change();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_tx_framed.md
UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
REQ-001 SHALL provide parameter p_bit_cnt, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL provide parameter p_div_w, default 16, width of runtime baud divisor.
REQ-003 SHALL have port i_clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_div  input  p_div_w  clock cycles per UART bit.
REQ-006 SHALL have port i_stop2  input  1  1 = two stop bits, 0 = one.
REQ-007 SHALL have port i_parity  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-008 SHALL have port i_fifo_rd_data  input  p_bit_cnt  byte from FIFO, valid the cycle after o_fifo_rd_en.
REQ-009 SHALL have port i_fifo_empty  input  1  FIFO empty flag.
REQ-010 SHALL have port o_fifo_rd_en  output  1  one-cycle FIFO pop strobe.
REQ-011 SHALL have port o_sig  output  1  serial line, idle high.
REQ-012 SHALL have port o_busy  output  1  high from REQ through last stop bit.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse in the cycle after the last stop-bit period ends.

Function
REQ-014 SHALL implement states IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
REQ-015 IDLE -> REQ when i_fifo_empty = 0; o_fifo_rd_en = 1 exactly while in REQ; REQ -> LOAD unconditionally.
REQ-016 LOAD SHALL capture i_fifo_rd_data, i_div, i_stop2, i_parity; config changes mid-frame SHALL have no effect on the current frame.
REQ-017 Captured divisor below 2 SHALL be treated as 2; bit period = captured divisor cycles exactly.
REQ-018 START drives 0 for one bit period; DATA drives p_bit_cnt bits LSB first; PARITY (if enabled) one bit; STOP drives 1 for one or two bit periods.
REQ-019 Even parity bit = XOR of data bits; odd parity bit = inverted XOR.
REQ-020 o_sig SHALL be 1 in IDLE, REQ, LOAD and STOP; first START cycle is the cycle after LOAD.
REQ-021 At the end of the last stop period: next state REQ if i_fifo_empty = 0, else IDLE; back-to-back frames SHALL be separated by exactly 2 idle-high cycles (REQ, LOAD).
REQ-022 Bit and delay counters SHALL be sized with $clog2 of their maxima and never wrap during a frame.
REQ-023 i_fifo_empty is sampled only in IDLE and at end of stop; it is ignored in other states.

Reset
REQ-024 While i_rst = 1: state IDLE, o_sig = 1, o_fifo_rd_en = 0, o_busy = 0, o_done = 0 on the next edge.
REQ-025 Reset mid-frame SHALL abort the frame with no o_done pulse; the popped byte is discarded.
REQ-026 Power-up initial state SHALL equal the reset state.

Configuration
REQ-027 Macro UART_TX_FRAMED_PARITY_EN: when defined, the PARITY state and i_parity decoding are compiled in.
REQ-028 Without UART_TX_FRAMED_PARITY_EN: i_parity is ignored, no PARITY state exists, and frames are start + data + stop only.

Verification
REQ-029 p_bit_cnt=8, i_div=4, parity none, 1 stop, push 0x55 -> o_sig 0,1,0,1,0,1,0,1,0,1 each held 4 cycles; o_done once; rd_en once.
REQ-030 Parity build, i_parity=01, data 0x07, i_div=3 -> parity bit 1 after data; i_parity=10 -> 0; frame 11 bits x 3 cycles.
REQ-031 i_stop2=1, i_div=5, two queued bytes -> stop high 10 cycles, then 2 high cycles, then second START; rd_en twice.
REQ-032 i_div=0 and i_div=1 -> each bit lasts 2 cycles.
REQ-033 Assert i_rst during DATA bit 3 -> o_sig=1 next cycle, o_busy=0, no o_done; after release with FIFO non-empty -> new frame starts.
REQ-034 Change i_div from 4 to 8 mid-frame -> current frame keeps 4-cycle bits; next frame uses 8.
